byte_sub_sequencer: RTL

// - Byte-serial SubBytes front/back end for the combinational 8-bit S-box lookup.
// - Accepts an NBYTES-wide word on a valid/ready input and streams it one byte per

---
 rtl/byte_sub_sequencer_if.sv | 28 ++
 rtl/byte_sub_sequencer.sv | 109 ++++++++++
 2 files changed

// File: rtl/byte_sub_sequencer_if.sv
// Valid/ready word bus around the byte-serial SubBytes sequencer.
// Parameter NBYTES sets the word width (8*NBYTES bits) and must match the sequencer.
// Signals:
//   in_valid/in_ready/in_data    - word handshake from the hash datapath
//   out_valid/out_ready/out_data - substituted word handshake back to it
// Modports: master = datapath side, slave = sequencer side.
interface byte_sub_sequencer_if #(
  parameter int unsigned NBYTES = 4
);
  localparam int unsigned DW = 8 * NBYTES;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/byte_sub_sequencer.sv
// Byte-serial SubBytes sequencer: takes an NBYTES-wide word, feeds it one byte
// per cycle (byte 0 first) into an external combinational S-box, collects the
// substituted bytes and returns the word on a valid/ready output.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   bus (slave) - in_valid/in_ready/in_data and out_valid/out_ready/out_data
//   sbox_in     - byte under substitution (8'h00 outside SUB)
//   sbox_out    - S-box result for sbox_in, same cycle
//   busy        - high while a word is in SUB or DONE
// Build option: BYTE_SUB_ROTWORD_EN rotates the result left by one byte
// (SubWord(RotWord) order); undefined gives the plain substituted word.
module byte_sub_sequencer #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  byte_sub_sequencer_if.slave   bus,
  output logic [7:0]            sbox_in,
  input  logic [7:0]            sbox_out,
  output logic                  busy
);

  localparam int unsigned DW = 8 * NBYTES;
  localparam int unsigned CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [DW-1:0] word_reg;
  logic [DW-1:0] res;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)      state_nxt = SUB;
      SUB:     if (cnt == LAST)       state_nxt = DONE;
      DONE:    if (bus.out_ready)     state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // Output decode from the state register and datapath registers
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    sbox_in       = 8'h00;
    case (state)
      IDLE: bus.in_ready = 1'b1;
      SUB: begin
        busy = 1'b1;
        // Byte lane select; a loop avoids out-of-range slices for NBYTES=1
        for (int i = 0; i < int'(NBYTES); i++) begin
          if (cnt == CW'(i)) sbox_in = word_reg[8*i +: 8];
        end
      end
      DONE: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Word capture, byte counter and result collection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_reg <= '0;
      res      <= '0;
      cnt      <= '0;
    end else begin
      if (state == IDLE && bus.in_valid) begin
        word_reg <= bus.in_data;
        cnt      <= '0;
      end
      if (state == SUB) begin
        for (int i = 0; i < int'(NBYTES); i++) begin
          if (cnt == CW'(i)) res[8*i +: 8] <= sbox_out;
        end
        cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
    end
  end

`ifdef BYTE_SUB_ROTWORD_EN
  // Rotate left one byte; for NBYTES=1 the shift is zero and this is res
  assign bus.out_data = DW'({res, res} >> (DW - 8));
`else
  assign bus.out_data = res;
`endif

endmodule
